// File: rtl/k2_pkg.sv
// Shared definitions for the K2 ALU request driver: op codes, FSM states and
// the default datapath width.
package k2_pkg;

  localparam int K2_WIDTH = 8;

  typedef enum logic [1:0] {
    ADD     = 2'd0,
    SUB     = 2'd1,
    ACC_ADD = 2'd2,
    ACC_SUB = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // ACC_* ops take operand a from the accumulator; bit 0 selects subtract.
  function automatic logic op_uses_acc(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_sub(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/alu_req_driver.sv
// Initiator for the registered add/sub ALU: accepts one request, drives the
// ALU operands, waits out its latency and returns result/flags with the tag.
//
// state | meaning
// IDLE  | req_ready high; a valid request is registered onto the ALU lines
// WAIT  | counting ALU latency; result captured when count hits ALU_LAT
// RESP  | rsp_valid high, rsp_* held until rsp_ready
module alu_req_driver
  import k2_pkg::*;
#(
  parameter int WIDTH   = K2_WIDTH,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             acc_clear,
  output logic             alu_rst_n,
  output logic             alu_s,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [WIDTH-1:0] acc_q
);

  localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(ALU_LAT);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_accept;
  logic               w_capture;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic [TAG_W-1:0]   r_tag;
  logic               r_alu_s;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_rsp_data;
  logic               r_rsp_carry;
  logic               r_rsp_zero;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [WIDTH-1:0]   w_acc_src;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: if (req_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: if (r_cnt == LAT_C) begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A same-cycle acc_clear wins over the stored accumulator for ACC_* operands.
  assign w_acc_src = acc_clear ? '0 : r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_op        <= '0;
      r_tag       <= '0;
      r_alu_s     <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_acc       <= '0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_rsp_tag   <= '0;
    end else begin
      if (r_state == IDLE && acc_clear) r_acc <= '0;
      if (w_accept) begin
        r_alu_a <= op_uses_acc(req_op) ? w_acc_src : req_a;
        r_alu_b <= req_b;
        r_alu_s <= op_is_sub(req_op);
        r_op    <= req_op;
        r_tag   <= req_tag;
        r_cnt   <= '0;
      end else if (r_state == WAIT && !w_capture) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // The ALU leaves carry stale on subtract, so it is masked here.
      if (w_capture) begin
        r_rsp_data  <= alu_out;
        r_rsp_carry <= op_is_sub(r_op) ? 1'b0 : alu_cout;
        r_rsp_zero  <= (alu_out == '0);
        r_rsp_tag   <= r_tag;
        r_acc       <= alu_out;
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign alu_rst_n = ~reset;
  assign alu_s     = r_alu_s;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_tag   = r_rsp_tag;
  assign acc_q     = r_acc;

endmodule
